// File: rtl/prbs_burst_sched_pkg.sv
// Shared types and constants for the PRBS burst scheduler.
// State encoding, default seed and LFSR tap positions.
package prbs_burst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] DEFAULT_SEED = 4'b1111;

  localparam int TAP_HI = 3;
  localparam int TAP_LO = 0;

endpackage

// File: rtl/prbs_burst_sched_lfsr4_core.sv
// 4-stage Fibonacci LFSR (x^4 + x^3 + 1 style, period 15).
// Synchronous load has priority over shift; reset loads the seed.
module lfsr4_core
  import prbs_burst_sched_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] seed,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (res || load) begin
      q <= seed;
    end else if (shift) begin
      q <= {q[TAP_HI] ^ q[TAP_LO], q[3:1]};
    end
  end

endmodule

// File: rtl/prbs_burst_sched.sv
// Round-robin scheduler sharing one PRBS-15 generator
// between two burst requesters.
module prbs_burst_sched
  import prbs_burst_sched_pkg::*;
#(
  parameter int         LEN_W = 8,
  parameter logic [3:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             res,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             bit_out,
  output logic             bit_vld,
  output logic             last,
  output logic [1:0]       done,
  output logic             busy
);

  state_t           state;
  state_t           nstate;
  logic             ptr;
  logic             win;
  logic             win_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_sel;
  logic             load;
  logic             shift;
  logic [3:0]       q;

  lfsr4_core u_lfsr (
    .clk   (clk),
    .res   (res),
    .load  (load),
    .shift (shift),
    .seed  (SEED),
    .q     (q)
  );

  assign len_sel = win ? len1 : len0;
  assign bit_out = q[0];
  assign busy    = (state != IDLE);

  always_comb begin
    nstate  = state;
    win_nxt = win;
    load    = 1'b0;
    shift   = 1'b0;
    gnt     = 2'b00;
    done    = 2'b00;
    bit_vld = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          nstate  = LOAD;
          win_nxt = (req == 2'b11) ? ptr : req[1];
        end
      end
      LOAD: begin
        gnt[win] = 1'b1;
        load     = 1'b1;
        nstate   = (len_sel == '0) ? DONE : RUN;
      end
      RUN: begin
        gnt[win] = 1'b1;
        bit_vld  = 1'b1;
        shift    = 1'b1;
        if (cnt == LEN_W'(1)) begin
          last   = 1'b1;
          nstate = DONE;
        end
      end
      DONE: begin
        gnt[win]  = 1'b1;
        done[win] = 1'b1;
        nstate    = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      ptr   <= 1'b0;
      win   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      win   <= win_nxt;
      if (state == LOAD) begin
        cnt <= len_sel;
      end else if (state == RUN) begin
        cnt <= cnt - LEN_W'(1);
      end
      // Hand priority to the other client once a burst finishes
      if (state == DONE) begin
        ptr <= ~win;
      end
    end
  end

endmodule

// File: tb/tb_prbs_burst_sched.sv
// Directed self-checking bench for prbs_burst_sched.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_prbs_burst_sched;

  logic       clk = 1'b0;
  logic       res;
  logic [1:0] req;
  logic [7:0] len0;
  logic [7:0] len1;
  logic [1:0] gnt;
  logic       bit_out;
  logic       bit_vld;
  logic       last;
  logic [1:0] done;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] seq = 15'b111101011001000;

  prbs_burst_sched dut (
    .clk     (clk),
    .res     (res),
    .req     (req),
    .len0    (len0),
    .len1    (len1),
    .gnt     (gnt),
    .bit_out (bit_out),
    .bit_vld (bit_vld),
    .last    (last),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1; req = 2'b00; len0 = 8'd0; len1 = 8'd0;
    tick();
    tick();
    res = 1'b0;
    n_checks++;
    if ({gnt, done, bit_vld, last, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs gnt=%b done=%b vld=%b last=%b busy=%b want all 0",
               gnt, done, bit_vld, last, busy);
    end
    n_checks++;
    if (bit_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bit_out got %b want 1", bit_out);
    end
  endtask

  task automatic test_single();
    req = 2'b01; len0 = 8'd15;
    tick();
    n_checks++;
    if (gnt !== 2'b01 || busy !== 1'b1 || bit_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_load gnt=%b busy=%b vld=%b want 01 1 0", gnt, busy, bit_vld);
    end
    tick();
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (bit_vld !== 1'b1 || bit_out !== seq[14-i] || last !== (i == 14)) begin
        n_fail++;
        $display("FAIL single_bit%0d vld=%b bit=%b last=%b want 1 %b %b",
                 i, bit_vld, bit_out, last, seq[14-i], (i == 14));
      end
      tick();
    end
    n_checks++;
    if (done !== 2'b01 || gnt !== 2'b01 || bit_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done done=%b gnt=%b vld=%b want 01 01 0", done, gnt, bit_vld);
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle gnt=%b busy=%b done=%b want 00 0 00", gnt, busy, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 2'b01; len0 = 8'd5;
    tick();
    tick();
    tick();
    tick();
    n_checks++;
    if (bit_vld !== 1'b1 || bit_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_run3 vld=%b bit=%b want 1 1", bit_vld, bit_out);
    end
    res = 1'b1; req = 2'b00;
    tick();
    res = 1'b0;
    n_checks++;
    if (gnt !== 2'b00 || bit_vld !== 1'b0 || busy !== 1'b0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_abort gnt=%b vld=%b busy=%b done=%b want 00 0 0 00",
               gnt, bit_vld, busy, done);
    end
    req = 2'b11; len0 = 8'd2; len1 = 8'd2;
    tick();
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_ptr gnt=%b want 01", gnt);
    end
    req = 2'b00; res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  task automatic test_simultaneous();
    req = 2'b11; len0 = 8'd3; len1 = 8'd4;
    tick();
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL sim_gnt0 gnt=%b want 01", gnt);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bit_vld !== 1'b1 || bit_out !== 1'b1 || last !== (i == 2)) begin
        n_fail++;
        $display("FAIL sim_c0_bit%0d vld=%b bit=%b last=%b", i, bit_vld, bit_out, last);
      end
      tick();
    end
    n_checks++;
    if (done !== 2'b01) begin
      n_fail++;
      $display("FAIL sim_done0 done=%b want 01", done);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL sim_gap busy=%b gnt=%b want 0 00", busy, gnt);
    end
    tick();
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL sim_gnt1 gnt=%b want 10", gnt);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bit_vld !== 1'b1 || bit_out !== seq[14-i] || last !== (i == 3)) begin
        n_fail++;
        $display("FAIL sim_c1_bit%0d vld=%b bit=%b last=%b", i, bit_vld, bit_out, last);
      end
      tick();
    end
    n_checks++;
    if (done !== 2'b10) begin
      n_fail++;
      $display("FAIL sim_done1 done=%b want 10", done);
    end
    tick();
    tick();
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL sim_rearb gnt=%b want 01", gnt);
    end
    req = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_end busy=%b want 0", busy);
    end
  endtask

  task automatic test_zero_len();
    int vld_seen = 0;
    req = 2'b10; len1 = 8'd0;
    tick();
    vld_seen += bit_vld;
    n_checks++;
    if (gnt !== 2'b10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_load gnt=%b busy=%b want 10 1", gnt, busy);
    end
    tick();
    vld_seen += bit_vld;
    n_checks++;
    if (done !== 2'b10 || last !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done done=%b last=%b want 10 0", done, last);
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (busy !== 1'b0 || vld_seen !== 0) begin
      n_fail++;
      $display("FAIL zero_end busy=%b vld_count=%0d want 0 0", busy, vld_seen);
    end
  endtask

  task automatic test_req_drop();
    req = 2'b01; len0 = 8'd8;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bit_vld !== 1'b1 || bit_out !== seq[14-i] || last !== (i == 7)) begin
        n_fail++;
        $display("FAIL drop_bit%0d vld=%b bit=%b last=%b want 1 %b %b",
                 i, bit_vld, bit_out, last, seq[14-i], (i == 7));
      end
      if (i == 1) req = 2'b00;
      tick();
    end
    n_checks++;
    if (done !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_done done=%b want 01", done);
    end
    tick();
    n_checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle gnt=%b busy=%b want 00 0", gnt, busy);
    end
  endtask

  task automatic test_reseed_wrap();
    req = 2'b01; len0 = 8'd20;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (bit_vld !== 1'b1 || bit_out !== seq[14-(i%15)] || last !== (i == 19)) begin
        n_fail++;
        $display("FAIL wrap_bit%0d vld=%b bit=%b last=%b want 1 %b %b",
                 i, bit_vld, bit_out, last, seq[14-(i%15)], (i == 19));
      end
      tick();
    end
    n_checks++;
    if (done !== 2'b01) begin
      n_fail++;
      $display("FAIL wrap_done done=%b want 01", done);
    end
    len0 = 8'd5;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bit_vld !== 1'b1 || bit_out !== seq[14-i] || last !== (i == 4)) begin
        n_fail++;
        $display("FAIL reseed_bit%0d vld=%b bit=%b last=%b want 1 %b %b",
                 i, bit_vld, bit_out, last, seq[14-i], (i == 4));
      end
      tick();
    end
    req = 2'b00;
    n_checks++;
    if (done !== 2'b01) begin
      n_fail++;
      $display("FAIL reseed_done done=%b want 01", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_burst();
    test_simultaneous();
    test_zero_len();
    test_req_drop();
    test_reseed_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_burst_sched.md
# prbs_burst_sched

Scheduler that shares one 4-stage m-sequence (PRBS-15) generator between two requesters. Each requester asks for a burst of N pseudo-random bits; the block arbitrates round-robin, reseeds the generator, streams exactly N bits tagged valid, then signals completion to the winner. It sits between the test-pattern clients and the PRBS datapath, so the generator is never driven by two clients at once.

## Interface
Parameters:
- `LEN_W`, default 8: width of burst-length inputs and the internal down-counter.
- `SEED`, default 4'b1111: LFSR value loaded at every grant; must be non-zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `res` in 1: reset, synchronous, active-high.
- `req` in 2: burst request per client; level, held until that client's `done`.
- `len0`, `len1` in LEN_W: burst length per client; sampled only in the grant cycle.
- `gnt` out 2: one-hot grant, high from LOAD through DONE inclusive.
- `bit_out` out 1: PRBS bit, LFSR stage 0.
- `bit_vld` out 1: `bit_out` is a valid burst bit.
- `last` out 1: marks the final valid bit of a burst.
- `done` out 2: one-cycle completion pulse to the granted client.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If `req` is non-zero, pick the winner and go to LOAD. Otherwise stay.
  - Single request: that client wins.
  - Both requesting: the client indicated by the round-robin pointer wins.
- LOAD:
  - `gnt[winner]`=1.
  - LFSR <= SEED.
  - Counter <= `len` of the winner.
  - If the latched length is 0, go straight to DONE with no valid bits. Otherwise go to RUN.
- RUN, every cycle:
  - `bit_vld`=1 and `bit_out`=LFSR[0].
  - LFSR[2:0] <= LFSR[3:1]; LFSR[3] <= LFSR[3] XOR LFSR[0] (mod-2 add).
  - Counter decrements by 1.
  - `last`=1 when counter==1; the next state is then DONE.
- DONE:
  - `done[winner]`=1 for one cycle.
  - Round-robin pointer <= the other client.
  - Next state is IDLE.
- `gnt` and `busy` drop on the IDLE cycle after DONE.
- Request changes after the grant (including `req` deasserting mid-burst) are ignored; the burst always runs to completion.
- A client that still holds `req` in IDLE re-competes. If the other client is requesting, the other client wins.
- Outside RUN: `bit_vld`=0, `last`=0, `bit_out`=LFSR[0]. `bit_out` is a don't-care for consumers.
- Arithmetic:
  - Counter is unsigned, LEN_W bits; maximum burst is 2^LEN_W−1.
  - Length 0 means an empty burst, not wrap-around.
- The LFSR is never loaded with zero. With SEED 1111, the sequence period is 15 bits: 111101011001000, repeating.

## Timing
- Reset (`res`=1 at a clock edge), next cycle:
  - state=IDLE, `gnt`=00, `done`=00, `bit_vld`=0, `last`=0, `busy`=0.
  - LFSR=SEED, so `bit_out`=SEED[0].
  - Counter=0; round-robin pointer=client 0.
- Reset during any state aborts immediately. No `done` pulse is issued.
- With `req` seen in IDLE at edge k:
  - `gnt` and `busy` high from cycle k+1 (LOAD).
  - First `bit_vld` in cycle k+2.
  - N valid bits in consecutive cycles, `last` on the Nth.
  - `done` in cycle k+N+2.
  - IDLE in k+N+3.
- Burst occupancy is N+3 cycles. A zero-length burst takes 3 cycles (IDLE, LOAD, DONE).
- Back-to-back bursts: one IDLE cycle between the DONE of one burst and the LOAD of the next.
- All outputs are registered or decoded from registered state only; there are no combinational paths from `req` or `len` to any output.

## Structure
- Shared package holds:
  - The state enum (IDLE/LOAD/RUN/DONE).
  - The default SEED constant.
  - The LFSR tap definition (stages 3 and 0).
- One sub-module, `lfsr4_core`:
  - Ports: `clk`, `res`, `load`, `shift`, `seed`, `q[3:0]`.
  - Synchronous load has priority over shift.
- FSM, arbiter pointer and length counter stay in the top module.

## Test plan
- Reset mid-burst: `req`=01, `len0`=5; assert `res` in the 3rd RUN cycle → next cycle `gnt`=00, `bit_vld`=0, `busy`=0; no `done` pulse; pointer=client 0.
- Single burst: `req`=01, `len0`=15 after reset → `gnt`=01 at k+1; `bit_out` at k+2..k+16 = 111101011001000; `last` at k+16; `done`=01 at k+17.
- Simultaneous requests: `req`=11, `len0`=3, `len1`=4 held → client 0 first (3 bits, `done`=01), one IDLE cycle, then client 1 (4 bits, `done`=10). The next arbitration grants client 0.
- Zero length: `req`=10, `len1`=0 → LOAD, then `done`=10; `bit_vld` never asserted; 3-cycle occupancy.
- Request drop mid-burst: `req`=01, `len0`=8; deassert `req` after 2 bits → all 8 bits are still emitted and `done`=01 fires; `gnt` is then low in IDLE.
- Reseed and wrap: `len0`=20 → bits 16–20 equal bits 1–5 (11110). A second burst restarts at 1111 because the LFSR is reseeded.
